grn_clt_gen: RTL and testbench

- Gaussian random number source feeding the Black-Scholes processor's const2 multiplier input; replaces the fixed pseudo pattern used in that path today.
- Three Tausworthe (taus88) uniform generators yield 12 independent bytes per cycle. Their centred sum gives an approximately N(0,1) sample by the central limit theorem.
- Output is one IEEE-754 single per cycle with a valid/ready handshake and full back-pressure.

---
 rtl/grn_clt_gen_pkg.sv | 39 +++
 rtl/grn_clt_gen_if.sv | 9 +
 rtl/grn_clt_gen_taus.sv | 54 +++++
 rtl/grn_clt_gen.sv | 115 +++++++++++
 tb/tb_grn_clt_gen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/grn_clt_gen_pkg.sv
// grn_pkg: shared constants and the magnitude-to-float helper for the
// Gaussian CLT generator (used by the RTL and by the bench model).
package grn_pkg;

  localparam int          NGEN         = 3;
  localparam int          GRN_LAT      = 4;
  localparam logic [31:0] MIN_OR       = 32'h0000_0010;
  localparam logic [31:0] DEFAULT_SEED = 32'h1234_5678;
  localparam logic [12:0] CENTRE       = 13'd1530;

  // Per-instance, per-component XOR constants that decorrelate the generators.
  localparam logic [31:0] SEED_K [3][3] = '{
    '{32'h0000_0000, 32'h9E37_79B9, 32'h7F4A_7C15},
    '{32'hB5AD_4ECE, 32'hDA94_2042, 32'hE4C2_F3A1},
    '{32'h2545_F491, 32'h5851_F42D, 32'h1405_7B7E}
  };

  // Exact conversion of (+/-) mag * 2^-8 into IEEE-754 single; mag==0 -> +0.0.
  function automatic logic [31:0] int_to_fp(input logic sgn, input logic [10:0] mag);
    logic [3:0]  pos;
    logic [33:0] sh;
    logic [7:0]  expo;
    logic [31:0] res;
    pos = 4'd0;
    for (int i = 0; i < 11; i++) begin
      pos = mag[i] ? 4'(i) : pos;
    end
    // Move the leading one to bit 23 so bits [22:0] are the left-aligned mantissa.
    sh   = 34'(mag) << (5'd23 - 5'(pos));
    expo = 8'd119 + 8'(pos);
    if (mag == 11'd0) begin
      res = 32'h0000_0000;
    end else begin
      res = {sgn, expo, sh[22:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/grn_clt_gen_if.sv
// Output stream of the Gaussian generator: valid/ready handshake plus sample.
interface grn_clt_gen_if;
  logic        valid;
  logic        ready;
  logic [31:0] dout;

  modport master (output valid, output dout, input ready);
  modport slave  (input valid, input dout, output ready);
endinterface

// File: rtl/grn_clt_gen_taus.sv
// taus_urng: one taus88 uniform generator (three 32-bit components).
// Components are seeded as (seed ^ SEED_K[G][j]) | MIN_OR so none can fall
// below the taus88 minimum-state limits.
module taus_urng
  import grn_pkg::*;
#(
  parameter int G = 0
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] seed_i,
  output logic [31:0] word_o
);

  logic [31:0] s1_q, s2_q, s3_q;
  logic [31:0] s1_d, s2_d, s3_d;
  logic [31:0] b1_s, b2_s, b3_s;

  function automatic logic [31:0] seeded(input logic [31:0] sd, input int j);
    return (sd ^ SEED_K[G][j]) | MIN_OR;
  endfunction

  // taus88 next state for all three components.
  always_comb begin
    b1_s = ((s1_q << 5'd13) ^ s1_q) >> 5'd19;
    s1_d = ((s1_q & 32'hFFFF_FFFE) << 5'd12) ^ b1_s;
    b2_s = ((s2_q << 5'd2) ^ s2_q) >> 5'd25;
    s2_d = ((s2_q & 32'hFFFF_FFF8) << 5'd4) ^ b2_s;
    b3_s = ((s3_q << 5'd3) ^ s3_q) >> 5'd11;
    s3_d = ((s3_q & 32'hFFFF_FFF0) << 5'd17) ^ b3_s;
  end

  // State register: reseed has priority over stepping; otherwise hold.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_q <= seeded(DEFAULT_SEED, 0);
      s2_q <= seeded(DEFAULT_SEED, 1);
      s3_q <= seeded(DEFAULT_SEED, 2);
    end else if (load_i) begin
      s1_q <= seeded(seed_i, 0);
      s2_q <= seeded(seed_i, 1);
      s3_q <= seeded(seed_i, 2);
    end else if (step_i) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign word_o = s1_q ^ s2_q ^ s3_q;

endmodule

// File: rtl/grn_clt_gen.sv
// grn_clt_gen: CLT Gaussian source. Twelve uniform bytes per cycle are summed,
// centred and emitted as an IEEE-754 single with valid/ready back-pressure.
// Pipeline: URNG state (stage 0) -> partial sums -> sign/|D| -> float out.
// Optional macro GRN_CNT_EN adds the sample_cnt handshake counter output.
module grn_clt_gen
  import grn_pkg::*;
(
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic [31:0]   seed,
  input  logic          seed_load,
  grn_clt_gen_if.master out_if
`ifdef GRN_CNT_EN
  ,
  output logic [31:0]   sample_cnt
`endif
);

  logic [31:0] word_s [NGEN];
  logic        adv_s, step_s;
  logic        v0_q, v1_q, v2_q, valid_q;
  logic [10:0] pa_q, pb_q, pa_d, pb_d;
  logic        sgn_q, sgn_d;
  logic [10:0] mag_q, mag_d;
  logic [31:0] dout_q;
  logic [11:0] sum_s;
  logic [12:0] diff_s, neg_s;

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign adv_s  = ~valid_q | out_if.ready;
  assign step_s = adv_s & en & ~seed_load;

  for (genvar g = 0; g < NGEN; g++) begin : g_urng
    taus_urng #(.G(g)) u_urng (
      .clk    (clk),
      .nreset (nreset),
      .load_i (seed_load),
      .step_i (step_s),
      .seed_i (seed),
      .word_o (word_s[g])
    );
  end

  // Two 6-byte partial sums, then centring and sign/magnitude split.
  always_comb begin
    pa_d = 11'(word_s[0][7:0])   + 11'(word_s[0][15:8])  + 11'(word_s[0][23:16]) +
           11'(word_s[0][31:24]) + 11'(word_s[1][7:0])   + 11'(word_s[1][15:8]);
    pb_d = 11'(word_s[1][23:16]) + 11'(word_s[1][31:24]) + 11'(word_s[2][7:0])   +
           11'(word_s[2][15:8])  + 11'(word_s[2][23:16]) + 11'(word_s[2][31:24]);
    sum_s  = 12'(pa_q) + 12'(pb_q);
    diff_s = 13'(sum_s) - CENTRE;
    neg_s  = 13'd0 - diff_s;
    sgn_d  = diff_s[12];
    mag_d  = diff_s[12] ? neg_s[10:0] : diff_s[10:0];
  end

  // Pipeline registers; data only moves with a valid token so bubbles keep
  // dout at its last value (and at +0.0 straight out of reset).
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      valid_q <= 1'b0;
      pa_q    <= 11'd0;
      pb_q    <= 11'd0;
      sgn_q   <= 1'b0;
      mag_q   <= 11'd0;
      dout_q  <= 32'h0000_0000;
    end else if (seed_load) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      valid_q <= 1'b0;
    end else if (adv_s) begin
      v0_q    <= en;
      v1_q    <= v0_q;
      v2_q    <= v1_q;
      valid_q <= v2_q;
      if (v0_q) begin
        pa_q <= pa_d;
        pb_q <= pb_d;
      end
      if (v1_q) begin
        sgn_q <= sgn_d;
        mag_q <= mag_d;
      end
      if (v2_q) begin
        dout_q <= int_to_fp(sgn_q, mag_q);
      end
    end
  end

  assign out_if.valid = valid_q;
  assign out_if.dout  = dout_q;

`ifdef GRN_CNT_EN
  logic [31:0] cnt_q;

  // Count accepted samples; a reseed clears it and drops a same-cycle handshake.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= 32'd0;
    end else if (seed_load) begin
      cnt_q <= 32'd0;
    end else if (valid_q & out_if.ready) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign sample_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_grn_clt_gen.sv
// Scoreboard bench for grn_clt_gen: the driver pushes the modelled sample for
// every advancing enabled cycle; a negedge monitor pops on each handshake.
module tb_grn_clt_gen;
  import grn_pkg::*;

  logic        clk = 1'b0;
  logic        nreset, en, seed_load;
  logic [31:0] seed;
`ifdef GRN_CNT_EN
  logic [31:0] sample_cnt;
`endif

  grn_clt_gen_if bus ();

  grn_clt_gen dut (
    .clk       (clk),
    .nreset    (nreset),
    .en        (en),
    .seed      (seed),
    .seed_load (seed_load),
    .out_if    (bus.master)
`ifdef GRN_CNT_EN
    ,
    .sample_cnt(sample_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] ms [3][3];
  int          n_pop   = 0;
  int          n_stat  = 0;
  bit          stats_on = 1'b0;
  longint      sum_d, sumsq_d;
  int          max_mag;
  logic [15:0] lfsr = 16'hACE1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h required %08h", name, act, req);
    end
  endtask

  task automatic check_bool(input string name, input bit ok, input real act);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %f", name, act);
    end
  endtask

  task automatic model_load(input logic [31:0] sd);
    for (int g = 0; g < 3; g++)
      for (int j = 0; j < 3; j++)
        ms[g][j] = (sd ^ SEED_K[g][j]) | 32'h0000_0010;
  endtask

  // taus88 step for all generators, then the 12-byte CLT sum.
  task automatic model_sample(output logic [31:0] f);
    logic [31:0] b, w;
    int          tot, d;
    tot = 0;
    for (int g = 0; g < 3; g++) begin
      b = ((ms[g][0] << 13) ^ ms[g][0]) >> 19;
      ms[g][0] = ((ms[g][0] & 32'hFFFF_FFFE) << 12) ^ b;
      b = ((ms[g][1] << 2) ^ ms[g][1]) >> 25;
      ms[g][1] = ((ms[g][1] & 32'hFFFF_FFF8) << 4) ^ b;
      b = ((ms[g][2] << 3) ^ ms[g][2]) >> 11;
      ms[g][2] = ((ms[g][2] & 32'hFFFF_FFF0) << 17) ^ b;
      w = ms[g][0] ^ ms[g][1] ^ ms[g][2];
      tot += int'(w[7:0]) + int'(w[15:8]) + int'(w[23:16]) + int'(w[31:24]);
    end
    d = tot - 1530;
    f = int_to_fp(d < 0, 11'(d < 0 ? -d : d));
  endtask

  // Float back to signed D (value * 256); out-of-range exponents give a huge value.
  function automatic int dec(input logic [31:0] f);
    int sh, mag;
    if (f[30:0] == 31'd0) return 0;
    sh = 142 - int'(f[30:23]);
    if (sh < 13 || sh > 23) mag = 99999;
    else mag = int'({1'b1, f[22:0]} >> sh);
    return f[31] ? -mag : mag;
  endfunction

  // Apply inputs for the next edge, update the scoreboard, then wait past it.
  task automatic cyc(input logic e, input logic sl, input logic [31:0] sd, input logic r);
    logic [31:0] f;
    en = e; seed_load = sl; seed = sd; bus.ready = r;
    if (nreset) begin
      if (sl) begin
        model_load(sd);
        if (bus.valid && r) exp_q = exp_q[0:0];
        else exp_q.delete();
      end else if ((!bus.valid || r) && e) begin
        model_sample(f);
        exp_q.push_back(f);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_pops(input int target, input logic [31:0] sd, input bit bp);
    int start, guard;
    logic r;
    start = n_pop;
    guard = 0;
    while ((n_pop - start) < target && guard < 8000) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      r = bp ? lfsr[0] : 1'b1;
      cyc(1'b1, 1'b0, sd, r);
      guard++;
    end
    check_bool("run_timeout", (n_pop - start) >= target, real'(n_pop - start));
  endtask

  task automatic drain(input logic [31:0] sd);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      cyc(1'b0, 1'b0, sd, 1'b1);
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: hold check while stalled, scoreboard pop on each handshake.
  initial begin
    logic        stall_prev;
    logic [31:0] dout_prev, e;
    int          d;
    stall_prev = 1'b0;
    dout_prev  = 32'h0;
    forever begin
      @(negedge clk);
      if (nreset === 1'b1) begin
        if (stall_prev && bus.valid) check("hold_stable", bus.dout, dout_prev);
        if (bus.valid && bus.ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_sample: got %08h with empty scoreboard", bus.dout);
          end else begin
            e = exp_q.pop_front();
            check("sample", bus.dout, e);
          end
          n_pop++;
          if (stats_on) begin
            d = dec(bus.dout);
            sum_d   += longint'(d);
            sumsq_d += longint'(d) * longint'(d);
            if ((d < 0 ? -d : d) > max_mag) max_mag = (d < 0 ? -d : d);
            n_stat++;
          end
        end
        stall_prev = bus.valid && !bus.ready;
        dout_prev  = bus.dout;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    real mean, var_r;
    nreset = 1'b0; en = 1'b0; seed_load = 1'b0; seed = 32'h0; bus.ready = 1'b0;
    model_load(DEFAULT_SEED);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_dout", bus.dout, 32'h0);
    nreset = 1'b1;

    check("fp_p256",  int_to_fp(1'b0, 11'd256),  32'h3F80_0000);
    check("fp_m256",  int_to_fp(1'b1, 11'd256),  32'hBF80_0000);
    check("fp_p1",    int_to_fp(1'b0, 11'd1),    32'h3B80_0000);
    check("fp_p1530", int_to_fp(1'b0, 11'd1530), 32'h40BF_4000);
    check("fp_zero",  int_to_fp(1'b0, 11'd0),    32'h0000_0000);

    // Idle after reset: nothing produced, state untouched (checked by next run).
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      check("idle_valid", 32'(bus.valid), 32'd0);
      check("idle_dout", bus.dout, 32'h0);
    end

    // Default-state run straight from reset.
    run_pops(64, 32'h0, 1'b0);
    drain(32'h0);

    // Explicit seed load, latency, then 64 bit-exact samples.
    cyc(1'b0, 1'b1, 32'h1234_5678, 1'b1);
    check("load_valid", 32'(bus.valid), 32'd0);
    for (int k = 1; k <= GRN_LAT; k++) begin
      cyc(1'b1, 1'b0, 32'h1234_5678, 1'b1);
      if (k == GRN_LAT - 1) check("lat_pre", 32'(bus.valid), 32'd0);
      if (k == GRN_LAT)     check("lat_first", 32'(bus.valid), 32'd1);
    end
    run_pops(60, 32'h1234_5678, 1'b0);

    // Mid-stream reseed with a live handshake and samples in flight.
    check("mid_live", 32'(bus.valid), 32'd1);
    cyc(1'b1, 1'b1, 32'h1234_5678, 1'b1);
    check("mid_flush", 32'(bus.valid), 32'd0);
`ifdef GRN_CNT_EN
    check("cnt_clear", sample_cnt, 32'd0);
`endif
    run_pops(20, 32'h1234_5678, 1'b0);
    drain(32'h1234_5678);

    // Back-pressure with pseudo-random ready.
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    run_pops(1000, 32'hDEAD_BEEF, 1'b1);
    drain(32'hDEAD_BEEF);

    // Statistics over 2^16 samples.
    cyc(1'b0, 1'b1, 32'h0BAD_F00D, 1'b0);
    sum_d = 0; sumsq_d = 0; max_mag = 0; n_stat = 0; stats_on = 1'b1;
    for (int guard = 0; guard < 70000 && n_stat < 65536; guard++)
      cyc(1'b1, 1'b0, 32'h0BAD_F00D, 1'b1);
    cyc(1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);
    stats_on = 1'b0;
    check("stat_count", 32'(n_stat), 32'd65536);
`ifdef GRN_CNT_EN
    check("cnt_65536", sample_cnt, 32'd65536);
`endif
    mean  = real'(sum_d) / 65536.0 / 256.0;
    var_r = real'(sumsq_d) / 65536.0 / 65536.0 - mean * mean;
    $display("[TB] stats mean=%f variance=%f max_mag=%0d", mean, var_r, max_mag);
    check_bool("stat_mean", (mean < 0.02) && (mean > -0.02), mean);
    check_bool("stat_var", (var_r > 0.97) && (var_r < 1.03), var_r);
    check_bool("stat_max", max_mag <= 1530, real'(max_mag));
    cyc(1'b0, 1'b1, 32'h0BAD_F00D, 1'b0);
    check("final_flush", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
